// File: rtl/float_result_buffer.sv
// Result FIFO behind float_alu: buffers {result, flags} pairs for writeback and
// keeps an accrued (sticky) exception register with an exception-pending flag.
module float_result_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [4:0]  EXC_MASK = 5'b11100
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic [4:0]                 in_flags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [4:0]                 out_flags,
  input  logic                       clear_sticky,
  output logic [4:0]                 sticky_flags,
  output logic                       exc_pending,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a beat transfers on a rising edge where valid and ready are both
  // high; the sender holds valid and data stable until that edge. in_ready is
  // a register, so it never depends combinationally on out_ready.

  logic [36:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic          in_ready_q;
  logic [4:0]    sticky_q;
  logic [4:0]    sticky_next;
  logic          exc_q;
  logic          push;
  logic          pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid & out_ready;

  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  // Newly accepted flags survive a same-cycle clear.
  always_comb begin
    sticky_next = sticky_q;
    if (push)
      sticky_next = (clear_sticky ? 5'b00000 : sticky_q) | in_flags;
    else if (clear_sticky)
      sticky_next = 5'b00000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      sticky_q   <= '0;
      exc_q      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q    <= count_next;
      in_ready_q <= (count_next < CW'(DEPTH));
      sticky_q   <= sticky_next;
      exc_q      <= |(sticky_next & EXC_MASK);
    end
  end

  // Storage is deliberately unreset; out_* are only meaningful with out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_result, in_flags};
  end

  assign out_valid    = (count_q != '0);
  assign out_result   = mem[rd_ptr][36:5];
  assign out_flags    = mem[rd_ptr][4:0];
  assign in_ready     = in_ready_q;
  assign sticky_flags = sticky_q;
  assign exc_pending  = exc_q;
  assign count        = count_q;

endmodule

// File: tb/tb_float_result_buffer.sv
// Directed bench for float_result_buffer: reset, backpressure, sticky flags,
// streaming throughput with pointer wrap, and asynchronous reset mid-stream.
module tb_float_result_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags;
  logic        clear_sticky;
  logic [4:0]  sticky_flags;
  logic        exc_pending;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] exp_q[$];

  float_result_buffer #(.DEPTH(DEPTH), .EXC_MASK(5'b11100)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .clear_sticky(clear_sticky), .sticky_flags(sticky_flags),
    .exc_pending(exc_pending), .count(count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one entry and hold it until accepted (bounded wait).
  task automatic push(input logic [31:0] r, input logic [4:0] f);
    logic acc;
    in_valid  = 1'b1;
    in_result = r;
    in_flags  = f;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      tick();
    end
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL push_timeout: entry %h not accepted, in_ready=%b required 1", r, in_ready);
    end
    in_valid = 1'b0;
  endtask

  // Pop one entry and compare it with the head of the expected queue.
  task automatic pop_check(input string name);
    logic [36:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: bench queue empty", name);
    end else begin
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || {out_result, out_flags} !== e) begin
        n_fail++;
        $display("FAIL %s: out_valid=%b data=%h/%b required 1 %h/%b",
                 name, out_valid, out_result, out_flags, e[36:5], e[4:0]);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0;
    out_ready = 1'b0; clear_sticky = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({out_valid, count, sticky_flags, exc_pending, in_ready} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_state: v=%b cnt=%0d st=%b exc=%b rdy=%b required all 0",
               out_valid, count, sticky_flags, exc_pending, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_result = 32'h423AC000; in_flags = 5'b00000; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h423AC000 || out_flags !== 5'b00000 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL single_visible: v=%b data=%h/%b cnt=%0d required 1 423ac000/00000 1",
               out_valid, out_result, out_flags, count);
    end
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || sticky_flags !== 5'b00000) begin
      n_fail++;
      $display("FAIL single_popped: v=%b cnt=%0d st=%b required 0 0 00000",
               out_valid, count, sticky_flags);
    end
  endtask

  task automatic test_full_backpressure();
    out_ready = 1'b0;
    push(32'h3CA3D70B, 5'b00001); exp_q.push_back({32'h3CA3D70B, 5'b00001});
    push(32'h7F800000, 5'b00101); exp_q.push_back({32'h7F800000, 5'b00101});
    push(32'h7FC00000, 5'b10000); exp_q.push_back({32'h7FC00000, 5'b10000});
    push(32'hC32B8000, 5'b00000); exp_q.push_back({32'hC32B8000, 5'b00000});
    n_checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state: cnt=%0d rdy=%b required 4 0", count, in_ready);
    end
    // Fifth entry waits while full.
    in_valid = 1'b1; in_result = 32'h40490FDB; in_flags = 5'b00001;
    repeat (3) tick();
    n_checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL held_off: cnt=%0d rdy=%b required 4 0", count, in_ready);
    end
    // Pop with push pending: no same-cycle push.
    pop_check("order_0");
    n_checks++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pop_from_full: cnt=%0d rdy=%b required 3 1", count, in_ready);
    end
    tick();
    in_valid = 1'b0;
    exp_q.push_back({32'h40490FDB, 5'b00001});
    n_checks++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL fifth_accepted: cnt=%0d required 4", count);
    end
    for (int i = 1; i <= 4; i++) pop_check($sformatf("order_%0d", i));
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drained: cnt=%0d v=%b required 0 0", count, out_valid);
    end
  endtask

  task automatic test_sticky_clear();
    n_checks++;
    if (sticky_flags !== 5'b10101 || exc_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_accrued: st=%b exc=%b required 10101 1", sticky_flags, exc_pending);
    end
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    n_checks++;
    if (sticky_flags !== 5'b00000 || exc_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_cleared: st=%b exc=%b required 00000 0", sticky_flags, exc_pending);
    end
  endtask

  task automatic test_clear_with_push();
    push(32'h3F800000, 5'b10001); exp_q.push_back({32'h3F800000, 5'b10001});
    n_checks++;
    if (sticky_flags !== 5'b10001 || exc_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_prior: st=%b exc=%b required 10001 1", sticky_flags, exc_pending);
    end
    clear_sticky = 1'b1;
    push(32'h40000000, 5'b00110); exp_q.push_back({32'h40000000, 5'b00110});
    clear_sticky = 1'b0;
    n_checks++;
    if (sticky_flags !== 5'b00110 || exc_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_push_wins: st=%b exc=%b required 00110 1", sticky_flags, exc_pending);
    end
    pop_check("clr_pop_0");
    pop_check("clr_pop_1");
  endtask

  task automatic test_back_to_back();
    logic [31:0] nxt;
    logic        pu, po;
    int          pushes;
    for (int i = 0; i < DEPTH; i++) begin
      push(32'hA0000000 + i, 5'(i)); exp_q.push_back({32'hA0000000 + i, 5'(i)});
    end
    nxt = 32'hB0000000;
    pushes = 0;
    in_valid = 1'b1; in_result = nxt; in_flags = 5'(nxt[3:0]);
    out_ready = 1'b1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_start_full: rdy=%b required 0", in_ready);
    end
    for (int c = 0; c < 16; c++) begin
      pu = in_ready;
      po = out_valid;
      if (po) begin
        logic [36:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 37'h0;
        n_checks++;
        if ({out_result, out_flags} !== e) begin
          n_fail++;
          $display("FAIL stream_data_%0d: got %h/%b required %h/%b",
                   c, out_result, out_flags, e[36:5], e[4:0]);
        end
      end
      if (pu) begin
        exp_q.push_back({in_result, in_flags});
        pushes++;
      end
      tick();
      if (pu) begin
        nxt = nxt + 1;
        in_result = nxt; in_flags = 5'(nxt[3:0]);
      end
      n_checks++;
      if (count < 3'd3 || count > 3'd4 || 32'(count) != exp_q.size()) begin
        n_fail++;
        $display("FAIL stream_count_%0d: cnt=%0d required %0d (3..4)", c, count, exp_q.size());
      end
    end
    n_checks++;
    if (pushes < 12) begin
      n_fail++;
      $display("FAIL stream_throughput: pushes=%0d required >=12", pushes);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    while (exp_q.size() != 0) pop_check("stream_drain");
  endtask

  task automatic test_async_reset();
    push(32'h11111111, 5'b00100);
    push(32'h22222222, 5'b00000);
    push(32'h33333333, 5'b01000);
    n_checks++;
    if (count !== 3'd3 || exc_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: cnt=%0d exc=%b required 3 1", count, exc_pending);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, count, sticky_flags, exc_pending, in_ready} !== 11'b0) begin
      n_fail++;
      $display("FAIL async_reset: v=%b cnt=%0d st=%b exc=%b rdy=%b required all 0",
               out_valid, count, sticky_flags, exc_pending, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset_empty: v=%b cnt=%0d rdy=%b required 0 0 1", out_valid, count, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_backpressure();
    test_sticky_clear();
    test_clear_with_push();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
